// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared op codes, command type and JK next-state function
package jk_seq_pkg;

   localparam int JK_CNT_W = 4;

   localparam logic [1:0] OP_HOLD   = 2'b00;
   localparam logic [1:0] OP_RESET  = 2'b01;
   localparam logic [1:0] OP_SET    = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   typedef struct packed {
      logic [1:0]          op;
      logic [JK_CNT_W-1:0] len;
   } jk_cmd_t;

   function automatic logic jk_next(input logic q, input logic j, input logic k);
      case ({j, k})
         OP_HOLD:  return q;
         OP_RESET: return 1'b0;
         OP_SET:   return 1'b1;
         default:  return ~q;
      endcase
   endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// rtl/jk_cmd_fifo.sv - synchronous command FIFO with occupancy level
module jk_cmd_fifo #(
   parameter int DW    = 6,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [LW-1:0] level_q;
   logic          do_push;
   logic          do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_q];
   assign level   = level_q;

   // Storage carries no reset; only pointers and level define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - queued command sequencer driving JK inputs
// with a shadow Q model that tracks the downstream flip-flop.
module jk_cmd_sequencer
   import jk_seq_pkg::*;
#(
   parameter int CNT_W      = JK_CNT_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        areset_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [1:0]                  cmd_op,
   input  logic [CNT_W-1:0]            cmd_len,
   output logic                        j,
   output logic                        k,
   output logic                        busy,
   output logic                        q_model,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               j_q, j_d;
   logic               k_q, k_d;
   logic               q_q, q_d;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W+1:0]   head;
   logic [1:0]         head_op;
   logic [CNT_W-1:0]   head_len;

   jk_cmd_fifo #(
      .DW    (CNT_W + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (areset_n),
      .push  (cmd_valid && cmd_ready),
      .pop   (pop),
      .din   ({cmd_op, cmd_len}),
      .dout  (head),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cmd_ready = !fifo_full;
   assign head_op   = head[CNT_W+1:CNT_W];
   assign head_len  = head[CNT_W-1:0];
   assign j         = j_q;
   assign k         = k_q;
   assign busy      = (state_q == S_RUN);
   assign q_model   = q_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      j_d     = j_q;
      k_d     = k_q;
      pop     = 1'b0;
      q_d     = jk_next(q_q, j_q, k_q);
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               {j_d, k_d} = head_op;
               cnt_d      = head_len;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!fifo_empty) begin
               // Chain straight into the next command so j/k never bubble.
               pop        = 1'b1;
               {j_d, k_d} = head_op;
               cnt_d      = head_len;
            end else begin
               j_d     = 1'b0;
               k_d     = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         j_q     <= 1'b0;
         k_q     <= 1'b0;
         q_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         j_q     <= j_d;
         k_q     <= k_d;
         q_q     <= q_d;
      end
   end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - scoreboard bench for jk_cmd_sequencer
module tb_jk_cmd_sequencer;
   import jk_seq_pkg::*;

   logic       clk = 1'b0;
   logic       areset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_len = 4'd0;
   logic       cmd_ready;
   logic       j;
   logic       k;
   logic       busy;
   logic       q_model;
   logic [2:0] fifo_level;

   int      total = 0;
   int      bad = 0;
   bit      mon_en = 1'b0;
   jk_cmd_t sb[$];

   jk_cmd_sequencer #(.CNT_W(4), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .areset_n   (areset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_len    (cmd_len),
      .j          (j),
      .k          (k),
      .busy       (busy),
      .q_model    (q_model),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a falling edge; records the command if the coming edge accepts it.
   task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] len);
      jk_cmd_t c;
      cmd_valid = v;
      cmd_op    = op;
      cmd_len   = len;
      #1;
      if (v && cmd_ready && mon_en) begin
         c.op  = op;
         c.len = len;
         sb.push_back(c);
      end
   endtask

   task automatic idle_drive();
      drive(1'b0, 2'($urandom), 4'($urandom));
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int w = 0; w < 300 && !done; w++) begin
         @(negedge clk);
         idle_drive();
         done = !busy && (fifo_level == 3'd0);
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL wait_idle: timeout busy=%0b level=%0d", busy, fifo_level);
      end
   endtask

   // Monitor: independent JK equation for q, and per-command duration/op from the scoreboard.
   initial begin
      logic    qm;
      logic    jp;
      logic    kp;
      int      rem;
      jk_cmd_t cur;
      qm  = 1'b0;
      jp  = 1'b0;
      kp  = 1'b0;
      rem = 0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            qm  = 1'b0;
            jp  = 1'b0;
            kp  = 1'b0;
            rem = 0;
         end else begin
            qm = (jp & ~qm) | (~kp & qm);
            check("q_model", 32'(q_model), 32'(qm));
            if (busy) begin
               if (rem == 0) begin
                  if (sb.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL sb_underflow: busy with no accepted command pending, jk=%0b%0b", j, k);
                  end else begin
                     cur = sb.pop_front();
                     rem = int'(cur.len) + 1;
                  end
               end
               check("jk_op", 32'({j, k}), 32'(cur.op));
               if (rem > 0) rem--;
            end else begin
               check("idle_jk", 32'({j, k}), 32'd0);
               check("cmd_duration_left", 32'(rem), 32'd0);
            end
            jp = j;
            kp = k;
         end
      end
   end

   initial begin
      logic [13:0] jk_seq;
      logic [6:0]  q_seq;
      logic [6:0]  b_seq;
      int          resumed;
      bit          found;
      bit          got;
      logic [1:0]  rop;
      logic [3:0]  rlen;

      // Reset
      repeat (3) @(negedge clk);
      check("rst_j", 32'(j), 32'd0);
      check("rst_k", 32'(k), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_q", 32'(q_model), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_level", 32'(fifo_level), 32'd0);
      areset_n = 1'b1;
      @(posedge clk);
      #2 mon_en = 1'b1;

      // Back-to-back: 10/len0, 11/len2, 01/len1 on consecutive edges
      jk_seq = '0;
      q_seq  = '0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            jk_seq = {jk_seq[11:0], j, k};
            q_seq  = {q_seq[5:0], q_model};
         end
         case (c)
            0:       drive(1'b1, OP_SET, 4'd0);
            1:       drive(1'b1, OP_TOGGLE, 4'd2);
            2:       drive(1'b1, OP_RESET, 4'd1);
            default: idle_drive();
         endcase
      end
      check("b2b_jk_seq", 32'(jk_seq), 32'(14'b10_11_11_11_01_01_00));
      check("b2b_q_seq", 32'(q_seq), 32'(7'b0101000));

      // Single SET len=2: samples taken after edges t..t+5
      jk_seq = '0;
      q_seq  = '0;
      b_seq  = '0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c >= 1) begin
            jk_seq = {jk_seq[11:0], j, k};
            q_seq  = {q_seq[5:0], q_model};
            b_seq  = {b_seq[5:0], busy};
         end
         if (c == 0) drive(1'b1, OP_SET, 4'd2);
         else        idle_drive();
      end
      check("set_jk_seq", 32'(jk_seq), 32'(12'b00_10_10_10_00_00));
      check("set_q_seq", 32'(q_seq), 32'(6'b001111));
      check("set_busy_seq", 32'(b_seq), 32'(6'b011100));

      // Full queue behind a long hold
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 0) drive(1'b1, OP_HOLD, 4'd15);
         else        drive(1'b1, 2'($urandom), 4'($urandom_range(0, 3)));
      end
      @(negedge clk);
      check("full_level", 32'(fifo_level), 32'd4);
      check("full_ready", 32'(cmd_ready), 32'd0);
      drive(1'b1, OP_TOGGLE, 4'd9);
      found = 1'b0;
      for (int w = 0; w < 40 && !found; w++) begin
         @(negedge clk);
         if (fifo_level != 3'd4) begin
            found = 1'b1;
            check("after_pop_level", 32'(fifo_level), 32'd3);
            check("after_pop_ready", 32'(cmd_ready), 32'd1);
            idle_drive();
         end else begin
            check("stall_ready", 32'(cmd_ready), 32'd0);
            drive(1'b1, OP_TOGGLE, 4'd9);
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL full_drain: level stuck at %0d", fifo_level);
         idle_drive();
      end
      wait_idle();

      // Asynchronous reset in the middle of a toggle run
      @(posedge clk);
      #2 mon_en = 1'b0;
      check("sb_drained", 32'(sb.size()), 32'd0);
      @(negedge clk);
      drive(1'b1, OP_TOGGLE, 4'd7);
      @(negedge clk);
      drive(1'b1, OP_SET, 4'd3);
      @(negedge clk);
      idle_drive();
      repeat (2) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_level", 32'(fifo_level), 32'd1);
      @(posedge clk);
      #2 areset_n = 1'b0;
      #1;
      check("mid_rst_jk", 32'({j, k}), 32'd0);
      check("mid_rst_level", 32'(fifo_level), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_q", 32'(q_model), 32'd0);
      check("mid_rst_ready", 32'(cmd_ready), 32'd1);
      #1 areset_n = 1'b1;
      resumed = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy || j || k) resumed++;
      end
      check("no_resume_cycles", 32'(resumed), 32'd0);
      @(posedge clk);
      #2 mon_en = 1'b1;

      // Randomized command stream with valid gaps
      for (int n = 0; n < 400; n++) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            idle_drive();
         end
         rop = 2'($urandom);
         case ($urandom_range(0, 3))
            0:       rlen = 4'd0;
            1:       rlen = 4'd15;
            default: rlen = 4'($urandom_range(0, 6));
         endcase
         got = 1'b0;
         for (int w = 0; w < 100 && !got; w++) begin
            @(negedge clk);
            drive(1'b1, rop, rlen);
            got = cmd_ready;
         end
         if (!got) begin
            total++;
            bad++;
            $display("FAIL rand_accept: cmd %0d never accepted", n);
         end
      end
      @(negedge clk);
      idle_drive();
      wait_idle();
      repeat (3) @(negedge clk);
      check("sb_leftover", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
